// File: rtl/fpu_pkg.sv
// Shared types and constants for the FP issue controller: operation codes,
// controller states, rounding-mode encodings, fflags bit positions and the
// layout of one buffered decoded op.
package fpu_pkg;

    typedef enum logic [4:0] {
        OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_SQRT,
        OP_SGNJ, OP_SGNJN, OP_SGNJX, OP_MIN, OP_MAX,
        OP_CVT_W, OP_CVT_WU, OP_MV_XW, OP_MV_WX, OP_CLASS,
        OP_EQ, OP_LT, OP_LE, OP_MADD, OP_MSUB, OP_NMSUB
    } fpu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT,
        ST_WB
    } fpu_state_e;

    // Rounding-mode encodings (101 and 110 are reserved).
    localparam logic [2:0] RM_RNE = 3'd0;
    localparam logic [2:0] RM_RTZ = 3'd1;
    localparam logic [2:0] RM_RDN = 3'd2;
    localparam logic [2:0] RM_RUP = 3'd3;
    localparam logic [2:0] RM_RMM = 3'd4;
    localparam logic [2:0] RM_DYN = 3'd7;

    // fflags bit positions.
    localparam int FLAG_NX = 0;
    localparam int FLAG_UF = 1;
    localparam int FLAG_OF = 2;
    localparam int FLAG_DZ = 3;
    localparam int FLAG_NV = 4;
    localparam int FLAG_W  = 5;

    // Decoder class that the FPU datapath can execute.
    localparam logic [1:0] TYPE_FP_ARITH = 2'b11;

    typedef struct packed {
        logic [1:0] itype;
        logic [4:0] op;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rs3;
        logic [2:0] rm;
    } op_entry_t;

    // True when the 5-bit code names a member of fpu_op_e.
    function automatic logic is_fpu_op(input logic [4:0] op);
        return op <= OP_NMSUB;
    endfunction

    // True for the static rounding modes RNE..RMM.
    function automatic logic rm_is_static(input logic [2:0] rm);
        return rm <= RM_RMM;
    endfunction

endpackage

// File: rtl/fpu_op_fifo.sv
// Small synchronous FIFO holding decoded ops ahead of the issue FSM.
// Supports push and pop in the same cycle, including when full.
module fpu_op_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign full    = (count == CNT_FULL);
    assign empty   = (count == '0);
    assign rdata   = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is a power of two).
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Payload storage, written only on an accepted push.
    // NOTE: the array is deliberately not reset; occupancy comes from count, so stale entries are never consumed.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/fpu_issue_ctrl.sv
// Issue controller for the shared multi-cycle FPU: buffers decoded ops,
// resolves the dynamic rounding mode, drops illegal ops, starts the datapath,
// bounds the wait with a timeout and hands results to the FP write port.
module fpu_issue_ctrl
    import fpu_pkg::*;
#(
    parameter int DEPTH   = 2,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_type,
    input  logic [4:0]        in_op,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [4:0]        in_rs3,
    input  logic [2:0]        in_rm,
    input  logic [2:0]        frm,
    output logic              fpu_start,
    output logic [4:0]        fpu_op,
    output logic [4:0]        fpu_rs1,
    output logic [4:0]        fpu_rs2,
    output logic [4:0]        fpu_rs3,
    output logic [2:0]        fpu_rm,
    input  logic              fpu_done,
    input  logic [FLAG_W-1:0] fpu_flags,
    output logic              wb_valid,
    output logic [4:0]        wb_rd,
    input  logic              wb_ready,
    output logic [FLAG_W-1:0] fflags,
    input  logic              fflags_clr,
    output logic              illegal,
    output logic              timeout,
    output logic              busy
);

    localparam int            CW       = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    fpu_state_e                   state;
    op_entry_t                    in_entry;
    op_entry_t                    head;
    logic [$bits(op_entry_t)-1:0] head_bits;
    logic                         fifo_full;
    logic                         fifo_empty;
    logic                         pop;
    logic [2:0]                   head_rm;
    logic                         head_legal;
    logic [CW-1:0]                wait_cnt;

    assign in_entry = '{itype: in_type, op: in_op, rd: in_rd, rs1: in_rs1,
                        rs2: in_rs2, rs3: in_rs3, rm: in_rm};
    assign head     = op_entry_t'(head_bits);
    assign in_ready = !fifo_full;
    assign pop      = (state == ST_IDLE) && !fifo_empty;
    assign busy     = (state != ST_IDLE) || !fifo_empty;

    fpu_op_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(op_entry_t))
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (in_valid && in_ready),
        .pop   (pop),
        .wdata (in_entry),
        .rdata (head_bits),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Resolve the head's rounding mode against frm and decide whether it can execute.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        head_rm    = head.rm;
        head_legal = 1'b0;
        if (head.rm == RM_DYN) head_rm = frm;
        head_legal = (head.itype == TYPE_FP_ARITH) && rm_is_static(head_rm) && is_fpu_op(head.op);
    end

    // Issue FSM with registered handshake outputs and held operand fields.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            fpu_start <= 1'b0;
            fpu_op    <= '0;
            fpu_rs1   <= '0;
            fpu_rs2   <= '0;
            fpu_rs3   <= '0;
            fpu_rm    <= '0;
            wb_valid  <= 1'b0;
            wb_rd     <= '0;
            illegal   <= 1'b0;
            timeout   <= 1'b0;
            wait_cnt  <= '0;
        end else begin
            fpu_start <= 1'b0;
            illegal   <= 1'b0;
            timeout   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        if (head_legal) begin
                            fpu_op    <= head.op;
                            fpu_rs1   <= head.rs1;
                            fpu_rs2   <= head.rs2;
                            fpu_rs3   <= head.rs3;
                            fpu_rm    <= head_rm;
                            wb_rd     <= head.rd;
                            fpu_start <= 1'b1;
                            state     <= ST_START;
                        end else begin
                            illegal <= 1'b1;
                        end
                    end
                end
                ST_START: begin
                    wait_cnt <= '0;
                    state    <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (fpu_done) begin
                        wb_valid <= 1'b1;
                        state    <= ST_WB;
                    end else if (wait_cnt == CNT_LAST) begin
                        timeout <= 1'b1;
                        state   <= ST_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                ST_WB: begin
                    if (wb_ready) begin
                        wb_valid <= 1'b0;
                        state    <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Sticky exception flags; a clear never masks flags arriving in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            fflags <= '0;
        end else begin
            fflags <= (fflags_clr ? '0 : fflags) |
                      ((state == ST_WAIT && fpu_done) ? fpu_flags : '0);
        end
    end

endmodule
